// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial sequence detector, optional saturating match counter (SEQ_DET_COUNT_EN)
module seq_detect_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               data_out
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(4'b1010);
  localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(4);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   FILL_MAX  = LEN_W'(MAX_LEN - 1);

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_p1;
  logic               cfg_ok;
  logic               match;

  // Build the compare window and the mask selecting its low len bits.
  always_comb begin
    window = {hist, data_in};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len) mask[i] = 1'b1;
    end
  end

  assign cfg_ok  = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};

  // Mealy match: enough history and the masked window equals the pattern.
  always_comb begin
    match = 1'b0;
    if (data_valid && !rst && !cfg_load && (fill_p1 >= {1'b0, len}) &&
        (((window ^ pat) & mask) == '0)) begin
      match = 1'b1;
    end
  end

  assign data_out = match;

  // Configuration, history and fill tracking; rst > cfg_load > data_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= RST_PAT;
      len  <= RST_LEN;
      ovl  <= 1'b1;
      hist <= '0;
      fill <= '0;
    end else if (cfg_load) begin
      // A rejected length leaves everything untouched; the data bit is dropped either way.
      if (cfg_ok) begin
        pat  <= cfg_pattern;
        len  <= cfg_len;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end
    end else if (data_valid) begin
      hist <= {hist[MAX_LEN-3:0], data_in};
      if (match && !ovl) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

`ifdef SEQ_DET_COUNT_EN
  // Saturating count of data_out pulses, cleared by reset or an accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (cfg_load) begin
      if (cfg_ok) match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed self-checking bench for seq_detect_prog
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       data_valid;
  logic       data_in;
  logic       data_out;
`ifdef SEQ_DET_COUNT_EN
  logic [1:0] match_count;
`endif

  int total  = 0;
  int passed = 0;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .data_out    (data_out)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Present one cycle of stream input, check data_out mid-cycle, then step past the edge.
  task automatic bit_step(input logic v, input logic d, input logic e, input string tag);
    data_valid = v;
    data_in    = d;
    #2;
    chk(32'(data_out), 32'(e), tag);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  // Send n valid bits (MSB of bits first) with their expected data_out values.
  task automatic send(input int n, input logic [31:0] bits, input logic [31:0] exps, input string tag);
    for (int i = 0; i < n; i++) begin
      bit_step(1'b1, bits[n-1-i], exps[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic v, input logic d, input string tag);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    data_valid  = v;
    data_in     = d;
    #2;
    chk(32'(data_out), 32'd0, tag);
    @(posedge clk);
    #1;
    cfg_load   = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic chk_cnt(input int exp, input string tag);
`ifdef SEQ_DET_COUNT_EN
    chk(32'(match_count), 32'(exp), tag);
`endif
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    data_valid = 1'b1; data_in = 1'b0;
    @(posedge clk);
    #2;
    chk(32'(data_out), 32'd0, "rst_out");
    @(posedge clk);
    #1;
    chk_cnt(0, "rst_cnt");
    rst = 1'b0; data_valid = 1'b0;

    // Default 1010 overlapping
    send(6, 32'b101010, 32'b000101, "dflt");
    chk_cnt(2, "dflt_cnt");

    // Non-overlapping 1010
    load(8'b1010, 4'd4, 1'b0, 1'b1, 1'b1, "ld_novl");
    chk_cnt(0, "ld_novl_cnt");
    send(8, 32'b10101010, 32'b00010001, "novl");
    chk_cnt(2, "novl_cnt");

    // Reconfigure to 110 overlapping, same-cycle bit dropped
    load(8'b110, 4'd3, 1'b1, 1'b1, 1'b1, "ld_110");
    send(7, 32'b1110110, 32'b0001001, "p110");

    // Rejected loads keep config and drop the data bit
    load(8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, "rej0");
    send(2, 32'b10, 32'b00, "rej0_drop");
    send(3, 32'b110, 32'b001, "rej0_keep");
    load(8'h00, 4'd9, 1'b0, 1'b1, 1'b0, "rej9");
    send(3, 32'b110, 32'b001, "rej9_keep");

    // Accepted load clears fill and drops its data bit
    load(8'b110, 4'd3, 1'b1, 1'b1, 1'b1, "ld_fill");
    send(2, 32'b10, 32'b00, "fill_clr");

    // Valid gaps: invalid cycles are transparent and never match
    load(8'b1010, 4'd4, 1'b1, 1'b0, 1'b0, "ld_gap");
    begin
      logic [3:0] gbits;
      logic [3:0] gexp;
      gbits = 4'b1010;
      gexp  = 4'b0001;
      for (int i = 0; i < 4; i++) begin
        bit_step(1'b1, gbits[3-i], gexp[3-i], $sformatf("gap_v%0d", i + 1));
        if (i < 3) begin
          for (int j = 0; j < 3; j++) begin
            bit_step(1'b0, j[0] ? 1'b1 : 1'b0, 1'b0, $sformatf("gap_i%0d_%0d", i + 1, j));
          end
        end
      end
    end

    // Reset mid-sequence reverts to 1010 overlapping
    load(8'b1100, 4'd4, 1'b0, 1'b0, 1'b0, "ld_1100");
    send(3, 32'b101, 32'b000, "pre_rst");
    rst = 1'b1; data_valid = 1'b1; data_in = 1'b0;
    #2;
    chk(32'(data_out), 32'd0, "mid_rst_out");
    @(posedge clk);
    #1;
    rst = 1'b0; data_valid = 1'b0;
    chk_cnt(0, "mid_rst_cnt");
    send(1, 32'b0, 32'b0, "post_rst0");
    send(6, 32'b101010, 32'b000101, "post_rst");

    // Saturation: 1111 overlapping on ten ones
    load(8'b1111, 4'd4, 1'b1, 1'b0, 1'b0, "ld_sat");
    send(4, 32'b1111, 32'b0001, "sat_a");
    chk_cnt(1, "sat_c1");
    send(1, 32'b1, 32'b1, "sat_b");
    chk_cnt(2, "sat_c2");
    send(1, 32'b1, 32'b1, "sat_c");
    chk_cnt(3, "sat_c3");
    send(4, 32'b1111, 32'b1111, "sat_d");
    chk_cnt(3, "sat_hold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable, parametrised serial sequence detector: the successor to the fixed-pattern 1010 Mealy detector in the same bit-serial front end. Compares the incoming bit stream against a runtime-loaded pattern of 1..MAX_LEN bits. Supports overlapping and non-overlapping detection and gaps in the input (qualified by a valid strobe). Raises a same-cycle Mealy match flag and, optionally, a saturating match counter.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; legal range 4..32.
- CNT_W, 16: match counter width in bits; legal range 2..32.
- LEN_W, derived as $clog2(MAX_LEN+1): width of the length field.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  load pattern, length and mode from cfg_* this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is received first, bit [0] last; bits above cfg_len-1 are ignored.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- data_valid  in  1  data_in is a valid stream bit this cycle.
- data_in  in  1  serial stream bit.
- data_out  out  1  Mealy match flag: high in the cycle the final pattern bit is presented.
- match_count  out  CNT_W  saturating match count; present only with SEQ_DET_COUNT_EN.

## Operation
- State:
  - Active pattern register `pat`, length `len` and mode `ovl`.
  - History shift register `hist` holding MAX_LEN-1 bits.
  - Fill counter `fill`, 0..MAX_LEN-1 saturating: the number of valid history bits usable toward a match.
- Reset state: `pat` = 4'b1010 zero-extended, `len` = 4, `ovl` = 1, `hist` = 0, `fill` = 0, match_count = 0. Out of reset the block detects overlapping 1010.
- Window: the low `len` bits of {hist, data_in}.
- Match condition: data_valid & !rst & !cfg_load & (fill >= len-1) & (window == pat, low `len` bits only).
- data_out equals the match condition. It is combinational and has no register stage.
- Valid bit with no cfg_load:
  - hist <= {hist[MAX_LEN-3:0], data_in}.
  - If match and !ovl: fill <= 0, because matched bits cannot be reused.
  - Otherwise: fill <= min(fill+1, MAX_LEN-1).
- data_valid low: hist, fill and the counter all hold, so gaps are transparent to detection.
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - Capture pat, len and ovl.
  - Clear hist, fill and match_count.
  - A data bit presented in the same cycle is discarded, and data_out stays 0.
- cfg_load with cfg_len == 0 or cfg_len > MAX_LEN: rejected with no state change. Because the data bit is also dropped, cfg_load still takes priority over data_valid.
- Priority: rst > cfg_load > data_valid.

## Timing
- Match latency: 0 cycles. data_out rises combinationally in the cycle that carries the last pattern bit.
- Update latency: fill, hist and match_count update on the following rising edge.
- Minimum spacing between data_out pulses:
  - Overlapping mode: 1 valid bit, e.g. pattern 11 on a run of ones.
  - Non-overlapping mode: `len` valid bits.
- New configuration takes effect for the first valid bit after the load cycle; a full `len` bits must then arrive before the first possible match.
- rst mid-sequence:
  - data_out is forced to 0 during the reset cycle.
  - Any partial match is lost.
  - The configuration reverts to 1010, overlapping.
- rst has no asynchronous path. While rst is high, the flops take their reset values on the edge regardless of other inputs.

## Configuration
- SEQ_DET_COUNT_EN defined:
  - The match_count port and counter exist.
  - The counter increments by 1 on every cycle where data_out is high.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It is cleared by rst and by an accepted cfg_load.
- SEQ_DET_COUNT_EN undefined: no counter logic and no match_count port. All other behaviour is identical.

## Test plan
- Reset defaults, overlapping: valid bits 1,0,1,0,1,0 → data_out high on bits 4 and 6 only; match_count = 2.
- Non-overlapping: cfg_load pattern 1010, len 4, ovl 0, then bits 1,0,1,0,1,0,1,0 → data_out high on bits 4 and 8 only, not on bit 6.
- Reconfigure: cfg_load pattern 3'b110, len 3, ovl 1, then bits 1,1,1,0,1,1,0 → data_out high on bits 4 and 7. Same-cycle data bit dropped. cfg_len = 0 or MAX_LEN+1 → config unchanged.
- Valid gaps: bits 1,0,1,0 of 1010 with data_valid low for 3 cycles between each → single data_out pulse on the 4th valid bit; data_out 0 on all invalid cycles even while data_in toggles.
- Reset mid-sequence: bits 1,0,1, then rst for 1 cycle, then 0 → no match; a following 1,0,1,0 → match on its 4th bit.
- Counter saturation (SEQ_DET_COUNT_EN, CNT_W = 2): pattern len 4 = 4'b1111 overlapping, 10 ones → match_count goes 1,2,3 and stays at 3. Build without the macro → same data_out sequence.
